// File: rtl/h14tx_lock_filter.sv
// rtl/h14tx_lock_filter.sv - PLL lock debounce: sync, qualify, glitch holdoff, loss counting
module h14tx_lock_filter #(
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_raw,
    input  logic       clr_loss,
    output logic       lock,
    output logic       lock_lost_stb,
    output logic [7:0] loss_count
);

    localparam int MAXC = (STABLE_CYCLES > GLITCH_CYCLES) ? STABLE_CYCLES : GLITCH_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GLITCH_LAST = CW'(GLITCH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_QUALIFY  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_loss;
    logic          r_stb;
    logic [7:0]    r_loss_count;
    logic          w_lock_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s = r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_UNLOCKED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // One counter serves both the qualify window and the glitch holdoff window.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_QUALIFY;
                    w_cnt_nxt   = '0;
                end
            end
            ST_QUALIFY: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_LOCKED: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HOLDOFF: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_LOCKED;
                end else if (r_cnt == GLITCH_LAST) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_loss      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A loss coinciding with a clear must still be counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stb        <= 1'b0;
            r_loss_count <= 8'd0;
        end else begin
            r_stb <= w_loss;
            if (clr_loss) begin
                r_loss_count <= w_loss ? 8'd1 : 8'd0;
            end else if (w_loss && (r_loss_count != 8'hFF)) begin
                r_loss_count <= r_loss_count + 8'd1;
            end
        end
    end

    assign lock          = (r_state == ST_LOCKED) || (r_state == ST_HOLDOFF);
    assign lock_lost_stb = r_stb;
    assign loss_count    = r_loss_count;

endmodule

// File: tb/tb_h14tx_lock_filter.sv
// tb/tb_h14tx_lock_filter.sv - directed and random-phase checks of h14tx_lock_filter
module tb_h14tx_lock_filter;

    localparam int S = 16;
    localparam int G = 4;

    logic       clk;
    logic       rst;
    logic       pll_lock_raw;
    logic       clr_loss;
    logic       lock;
    logic       lock_lost_stb;
    logic [7:0] loss_count;

    int checks;
    int errors;
    int stb_seen;

    logic       m_lock;
    logic       m_stb;
    int         m_loss;
    logic [1:0] m_hist;
    int         m_hi;
    int         m_lo;
    logic       prev_lock;

    h14tx_lock_filter #(
        .STABLE_CYCLES(S),
        .GLITCH_CYCLES(G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock_raw (pll_lock_raw),
        .clr_loss     (clr_loss),
        .lock         (lock),
        .lock_lost_stb(lock_lost_stb),
        .loss_count   (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns the number of edges until lock reads val; max+1 on timeout.
    task automatic wait_lock(input logic val, input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (lock === val) begin
                n = i;
                break;
            end
        end
    endtask

    // Run-length model: lock needs S+1 consecutive high samples of the
    // synchronized input; it is lost after G+1 consecutive low samples.
    task automatic model_edge();
        logic s;
        logic lost;
        s      = m_hist[1];
        m_hist = {m_hist[0], pll_lock_raw};
        lost   = 1'b0;
        if (!m_lock) begin
            m_hi = s ? m_hi + 1 : 0;
            if (m_hi == S + 1) begin
                m_lock = 1'b1;
                m_hi   = 0;
                m_lo   = 0;
            end
        end else begin
            m_lo = s ? 0 : m_lo + 1;
            if (m_lo == G + 1) begin
                m_lock = 1'b0;
                lost   = 1'b1;
                m_lo   = 0;
                m_hi   = 0;
            end
        end
        m_stb = lost;
        if (clr_loss) m_loss = lost ? 1 : 0;
        else if (lost && m_loss < 255) m_loss = m_loss + 1;
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_stb  = 1'b0;
        m_loss = 0;
        m_hist = 2'b00;
        m_hi   = 0;
        m_lo   = 0;
    endtask

    int n;
    int base;
    int stay;
    int phase;
    int len;

    initial begin
        checks       = 0;
        errors       = 0;
        stb_seen     = 0;
        prev_lock    = 1'b0;
        rst          = 1'b0;
        pll_lock_raw = 1'b0;
        clr_loss     = 1'b0;
        model_reset();
        fork
            forever begin
                @(posedge clk or posedge rst);
                if (rst) model_reset();
                else model_edge();
            end
            forever begin
                @(negedge clk);
                check("lock", lock, m_lock);
                check("lock_lost_stb", lock_lost_stb, m_stb);
                check("loss_count", loss_count, m_loss);
                if (lock_lost_stb) begin
                    stb_seen++;
                    check("stb_on_fall", {prev_lock, lock}, 2'b10);
                end
                prev_lock = lock;
            end
        join_none

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_lock", lock, 0);
        check("reset_stb", lock_lost_stb, 0);
        check("reset_loss", loss_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean qualification
        base = stb_seen;
        pll_lock_raw = 1'b1;
        wait_lock(1'b1, 60, n);
        check("rise_latency", n, 19);
        check("rise_loss", loss_count, 0);
        check("rise_no_stb", stb_seen - base, 0);

        @(negedge clk);
        rst = 1'b1;
        pll_lock_raw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Interrupted qualification restarts from scratch
        base = stb_seen;
        pll_lock_raw = 1'b1;
        repeat (13) @(posedge clk);
        @(negedge clk);
        pll_lock_raw = 1'b0;
        repeat (10) @(negedge clk);
        pll_lock_raw = 1'b1;
        wait_lock(1'b1, 60, n);
        check("requal_latency", n, 19);
        check("requal_no_stb", stb_seen - base, 0);
        check("requal_loss", loss_count, 0);

        // Glitch absorbed vs. glitch one cycle too long
        @(negedge clk);
        pll_lock_raw = 1'b0;
        repeat (4) @(negedge clk);
        pll_lock_raw = 1'b1;
        stay = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (lock !== 1'b1) stay = 0;
        end
        check("glitch4_hold", stay, 1);
        check("glitch4_loss", loss_count, 0);

        base = stb_seen;
        @(negedge clk);
        pll_lock_raw = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) pll_lock_raw = 1'b1;
            if (lock === 1'b0 && n == 0) n = i;
        end
        check("glitch5_fall_latency", n, 7);
        check("glitch5_one_stb", stb_seen - base, 1);
        check("glitch5_loss", loss_count, 1);

        // Saturation
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            pll_lock_raw = 1'b1;
            wait_lock(1'b1, 60, n);
            check("sat_rise_timeout", n <= 60, 1);
            @(negedge clk);
            pll_lock_raw = 1'b0;
            wait_lock(1'b0, 20, n);
            check("sat_fall_timeout", n <= 20, 1);
        end
        repeat (2) @(negedge clk);
        check("sat_loss", loss_count, 255);

        // Clear coinciding with a loss
        @(negedge clk);
        pll_lock_raw = 1'b1;
        wait_lock(1'b1, 60, n);
        check("clr_rise", n <= 60, 1);
        @(negedge clk);
        pll_lock_raw = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        clr_loss = 1'b1;
        @(posedge clk);
        #1;
        check("clr_with_loss", loss_count, 1);
        check("clr_with_loss_lock", lock, 0);
        @(negedge clk);
        clr_loss = 1'b0;

        // Reset while in holdoff
        @(negedge clk);
        pll_lock_raw = 1'b1;
        wait_lock(1'b1, 60, n);
        check("hold_rise", n, 19);
        @(negedge clk);
        pll_lock_raw = 1'b0;
        base = stb_seen;
        repeat (3) @(posedge clk);
        #2;
        check("holdoff_lock_high", lock, 1);
        rst = 1'b1;
        #1;
        check("rst_hold_lock", lock, 0);
        check("rst_hold_stb", lock_lost_stb, 0);
        check("rst_hold_loss", loss_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_hold_no_stb", stb_seen - base, 0);
        pll_lock_raw = 1'b1;
        wait_lock(1'b1, 60, n);
        check("post_rst_latency", n, 19);

        // Random-phase toggling
        for (int r = 0; r < 120; r++) begin
            @(negedge clk);
            phase = $urandom_range(1, 8);
            if (phase == 5) phase = 6;
            #(phase);
            pll_lock_raw = ~pll_lock_raw;
            len = pll_lock_raw ? $urandom_range(1, 30) : $urandom_range(1, 7);
            repeat (len) @(negedge clk);
        end
        pll_lock_raw = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/h14tx_lock_filter.md
H14TX_LOCK_FILTER -- requirements
Module: h14tx_lock_filter

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock-high cycles required before lock is declared (legal range 2..65535).
REQ-002 SHALL have parameter GLITCH_CYCLES, default 4: longest lock-low run, in cycles, absorbed without declaring loss (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: free-running reference clock, not derived from the PLL being monitored.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-high.
REQ-005 SHALL have port pll_lock_raw, input, 1 bit: raw PLL lock indicator, asynchronous to clk.
REQ-006 SHALL have port clr_loss, input, 1 bit: synchronous clear of loss_count.
REQ-007 SHALL have port lock, output, 1 bit: filtered lock; drives the downstream reset synchronizer's lock input.
REQ-008 SHALL have port lock_lost_stb, output, 1 bit: one-cycle pulse on each declared loss of lock.
REQ-009 SHALL have port loss_count, output, 8 bits: saturating count of declared losses.

Function
REQ-010 SHALL pass pll_lock_raw through a 2-flop synchronizer; all further logic SHALL use only the synchronized value (lock_s).
REQ-011 SHALL implement states Unlocked, Qualify, Locked, Holdoff, plus one shared counter sized for max(STABLE_CYCLES, GLITCH_CYCLES).
REQ-012 Unlocked: lock_s=1 -> Qualify with counter=0; otherwise remain.
REQ-013 Qualify: lock_s=0 -> Unlocked; counter==STABLE_CYCLES-1 -> Locked; otherwise counter increments.
REQ-014 Locked: lock_s=0 -> Holdoff with counter=0; otherwise remain.
REQ-015 Holdoff: lock_s=1 -> Locked; counter==GLITCH_CYCLES-1 with lock_s=0 -> Unlocked; otherwise counter increments.
REQ-016 lock SHALL be 1 exactly when state is Locked or Holdoff, decoded from registered state with no combinational path from pll_lock_raw.
REQ-017 Latency: with pll_lock_raw held high, lock SHALL rise after the (STABLE_CYCLES+3)th clk edge, counting from the first edge that samples pll_lock_raw high.
REQ-018 Latency: with pll_lock_raw held low from Locked, lock SHALL fall after the (GLITCH_CYCLES+3)th edge, counting from the first edge that samples it low.
REQ-019 A low run of at most GLITCH_CYCLES cycles on lock_s in Locked SHALL NOT drop lock; a run of GLITCH_CYCLES+1 cycles SHALL drop it.
REQ-020 Any lock_s=0 during Qualify SHALL restart qualification from Unlocked; partial credit is not retained.
REQ-021 lock_lost_stb SHALL be registered and high for exactly the one cycle in which lock first reads 0 after a Holdoff->Unlocked transition.
REQ-022 Qualify->Unlocked transitions SHALL NOT pulse lock_lost_stb or change loss_count.
REQ-023 loss_count SHALL increment by 1 on each Holdoff->Unlocked transition and saturate at 255.
REQ-024 clr_loss=1 SHALL set loss_count to 0 on the next edge; if a loss occurs in the same cycle, loss_count SHALL become 1.

Reset
REQ-025 rst=1 SHALL asynchronously force: both synchronizer flops to 0, state to Unlocked, counter to 0, lock=0, lock_lost_stb=0, loss_count=0.
REQ-026 Reset asserted mid-Qualify, Locked or Holdoff SHALL abandon progress; after release, qualification SHALL restart with the full STABLE_CYCLES requirement.
REQ-027 Reset asserted in Holdoff SHALL NOT pulse lock_lost_stb or increment loss_count.

Verification (STABLE_CYCLES=16, GLITCH_CYCLES=4 unless stated)
REQ-028 Release rst, raise pll_lock_raw and hold it -> lock rises after the 19th edge; loss_count=0; no strobe.
REQ-029 Drive pll_lock_raw low for 10 cycles in Qualify at counter=12, then high -> lock rises 19 edges after the re-rise.
REQ-030 In Locked, drive low pulses of 4 cycles and then 5 cycles -> 4-cycle pulse: lock stays 1; 5-cycle pulse: lock falls, one strobe, loss_count=1.
REQ-031 Cause 300 losses -> loss_count holds at 255; assert clr_loss in the same cycle as the next loss -> loss_count=1.
REQ-032 Assert rst while in Holdoff -> lock=0 immediately, no strobe, loss_count=0; after release, full 19-edge qualification.
REQ-033 Toggle pll_lock_raw asynchronously at random phase relative to clk -> lock never glitches, and every strobe coincides with a lock fall.
